// File: rtl/reg_file_pkg.sv
// Shared constants, types and helpers for the parametrised multi-port register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: set by issue-stage reservations, cleared by writeback.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rsv_en,
  input  logic [$clog2(NREGS)-1:0]            rsv_addr,
  input  logic                                wr_en,
  input  logic [$clog2(NREGS)-1:0]            wr_addr,
  input  logic [NUM_RD*$clog2(NREGS)-1:0]     rd_addr,
  output logic [NREGS-1:0]                    busy_vec,
  output logic [NUM_RD-1:0]                   rd_busy_raw
);

  localparam int AW = addr_w(NREGS);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_next;

  // A reservation in the same cycle as a release wins: it names a newer producer.
  always_comb begin
    busy_next = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (rsv_en && rsv_addr == AW'(r)) begin
        busy_next[r] = 1'b1;
      end else if (wr_en && wr_addr == AW'(r)) begin
        busy_next[r] = 1'b0;
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy_vec = busy_q;

  always_comb begin
    rd_busy_raw = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy_raw[i] = busy_q[rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with x0 hardwired to zero, optional write-to-read bypass
// and a busy scoreboard for pending writebacks.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_RD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]          rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic                            wr_en,
  input  logic [$clog2(NREGS)-1:0]        wr_addr,
  input  logic [XLEN-1:0]                 wr_data,
  input  logic                            rsv_en,
  input  logic [$clog2(NREGS)-1:0]        rsv_addr,
  output logic [NREGS-1:0]                busy_vec
);

  localparam int AW = addr_w(NREGS);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD must be between 1 and 4");
  end
  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("reg_file_mp: NREGS must be a power of 2 and at least 2");
  end

  logic [XLEN-1:0]   regs [NREGS];
  logic [NUM_RD-1:0] busy_raw;
  logic [NUM_RD-1:0] fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .busy_vec    (busy_vec),
    .rd_busy_raw (busy_raw)
  );

  // Forwarded data hides the pending flag unless the same cycle re-reserves the register.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    fwd     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] ra;
      ra = rd_addr[i*AW +: AW];
      fwd[i] = (BYPASS != 0) && rst_n && wr_en && (wr_addr == ra) && (ra != '0);
      if (ra == '0) begin
        rd_data[i*XLEN +: XLEN] = '0;
      end else if (fwd[i]) begin
        rd_data[i*XLEN +: XLEN] = wr_data;
      end else begin
        rd_data[i*XLEN +: XLEN] = regs[ra];
      end
      rd_busy[i] = busy_raw[i] && !(fwd[i] && !(rsv_en && rsv_addr == ra));
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: bypass and non-bypass default instances against an array model,
// plus a wide 64-bit/16-register/3-port instance checked with literal vectors.
module tb_reg_file_mp;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  rd_addr  = '0;
  logic        wr_en    = 1'b0;
  logic [4:0]  wr_addr  = '0;
  logic [31:0] wr_data  = '0;
  logic        rsv_en   = 1'b0;
  logic [4:0]  rsv_addr = '0;

  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_busy, b_rd_busy;
  logic [31:0] a_busy_vec, b_busy_vec;

  logic [11:0]  c_rd_addr  = '0;
  logic         c_wr_en    = 1'b0;
  logic [3:0]   c_wr_addr  = '0;
  logic [63:0]  c_wr_data  = '0;
  logic         c_rsv_en   = 1'b0;
  logic [3:0]   c_rsv_addr = '0;
  logic [191:0] c_rd_data;
  logic [2:0]   c_rd_busy;
  logic [15:0]  c_busy_vec;

  int vectors     = 0;
  int miscompares = 0;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(a_busy_vec)
  );

  reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(b_busy_vec)
  );

  reg_file_mp #(.XLEN(64), .NREGS(16), .NUM_RD(3), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .rsv_en(c_rsv_en),
    .rsv_addr(c_rsv_addr), .busy_vec(c_busy_vec)
  );

  // Architectural model: plain array of values and busy flags.
  logic [31:0] m_regs [32];
  logic        m_busy [32];

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] expData(input logic [4:0] addr, input bit byp);
    if (!rst_n || addr == 5'd0) return 32'd0;
    if (byp && wr_en && wr_addr == addr) return wr_data;
    return m_regs[addr];
  endfunction

  function automatic logic expBusy(input logic [4:0] addr, input bit byp);
    if (!rst_n || addr == 5'd0) return 1'b0;
    if (byp && wr_en && wr_addr == addr && !(rsv_en && rsv_addr == addr)) return 1'b0;
    return m_busy[addr];
  endfunction

  function automatic logic [31:0] expBusyVec();
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < 32; r++) v[r] = rst_n && m_busy[r];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] a;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      checkOutput($sformatf("byp data p%0d", p), {32'd0, a_rd_data[p*32 +: 32]}, {32'd0, expData(a, 1'b1)});
      checkOutput($sformatf("byp busy p%0d", p), {63'd0, a_rd_busy[p]}, {63'd0, expBusy(a, 1'b1)});
      checkOutput($sformatf("nobyp data p%0d", p), {32'd0, b_rd_data[p*32 +: 32]}, {32'd0, expData(a, 1'b0)});
      checkOutput($sformatf("nobyp busy p%0d", p), {63'd0, b_rd_busy[p]}, {63'd0, expBusy(a, 1'b0)});
    end
    checkOutput("byp busy_vec", {32'd0, a_busy_vec}, {32'd0, expBusyVec()});
    checkOutput("nobyp busy_vec", {32'd0, b_busy_vec}, {32'd0, expBusyVec()});
  end

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic re, input logic [4:0] ra, input logic [4:0] p0,
                               input logic [4:0] p1);
    @(posedge clk);
    #1;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
    rd_addr  = {p1, p0};
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Build up state, then drop reset mid-cycle with a write and reservation in flight.
    applyStimulus(1'b1, 5'd10, 32'h1111_1111, 1'b1, 5'd11, 5'd10, 5'd11);
    applyStimulus(1'b1, 5'd10, 32'h2222_2222, 1'b1, 5'd11, 5'd10, 5'd11);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset data p0", {32'd0, a_rd_data[31:0]}, 64'd0);
    checkOutput("reset data p1", {32'd0, a_rd_data[63:32]}, 64'd0);
    checkOutput("reset busy_vec", {32'd0, a_busy_vec}, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(1'b1, 5'd11, 32'd0, 1'b0, 5'd0, 5'd10, 5'd11);
    #2;
    checkOutput("post-reset write", {32'd0, a_rd_data[31:0]}, 64'h2222_2222);
    checkOutput("post-reset rsv", {32'd0, a_busy_vec}, 64'h800);
    checkOutput("byp hides busy", {63'd0, a_rd_busy[1]}, 64'd0);
    checkOutput("nobyp shows busy", {63'd0, b_rd_busy[1]}, 64'd1);

    applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 5'd0, 5'd5);
    #2;
    checkOutput("x0 no bypass", {32'd0, a_rd_data[31:0]}, 64'd0);
    checkOutput("x0 busy", {63'd0, a_rd_busy[0]}, 64'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd5);
    #2;
    checkOutput("x0 after write", {32'd0, a_rd_data[31:0]}, 64'd0);
    checkOutput("x5 after reset", {32'd0, a_rd_data[63:32]}, 64'd0);
    checkOutput("x0 busy_vec", {32'd0, a_busy_vec}, 64'd0);

    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    #2;
    checkOutput("x7 p0", {32'd0, a_rd_data[31:0]}, 64'h1234_5678);
    checkOutput("x7 p1", {32'd0, a_rd_data[63:32]}, 64'h1234_5678);
    checkOutput("x7 nobyp p1", {32'd0, b_rd_data[63:32]}, 64'h1234_5678);

    applyStimulus(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd7, 5'd9);
    #2;
    checkOutput("bypass p1", {32'd0, a_rd_data[63:32]}, 64'hA5A5_A5A5);
    checkOutput("nobyp old p1", {32'd0, b_rd_data[63:32]}, 64'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd9);
    #2;
    checkOutput("nobyp new p1", {32'd0, b_rd_data[63:32]}, 64'hA5A5_A5A5);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    #2;
    checkOutput("rsv not same cycle", {63'd0, a_rd_busy[0]}, 64'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    #2;
    checkOutput("x3 busy", {63'd0, a_rd_busy[0]}, 64'd1);
    checkOutput("x3 busy_vec", {63'd0, a_busy_vec[3]}, 64'd1);
    applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd3, 5'd0);
    #2;
    checkOutput("x3 release byp busy", {63'd0, a_rd_busy[0]}, 64'd0);
    checkOutput("x3 release byp data", {32'd0, a_rd_data[31:0]}, 64'h55);
    checkOutput("x3 release nobyp busy", {63'd0, b_rd_busy[0]}, 64'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    #2;
    checkOutput("x3 released", {63'd0, a_busy_vec[3]}, 64'd0);
    checkOutput("x3 data", {32'd0, a_rd_data[31:0]}, 64'h55);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd4);
    applyStimulus(1'b1, 5'd4, 32'h77, 1'b1, 5'd4, 5'd4, 5'd4);
    #2;
    checkOutput("x4 rerserved busy", {63'd0, a_rd_busy[0]}, 64'd1);
    checkOutput("x4 bypass data", {32'd0, a_rd_data[31:0]}, 64'h77);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd4, 5'd0);
    #2;
    checkOutput("x4 data", {32'd0, a_rd_data[31:0]}, 64'h77);
    checkOutput("x4 still busy", {63'd0, a_busy_vec[4]}, 64'd1);
    applyStimulus(1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 5'd4, 5'd0);
    #2;
    checkOutput("x0 rsv ignored", {32'd0, a_busy_vec}, 64'h10);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    checkOutput("all released", {32'd0, a_busy_vec}, 64'd0);

    // Wide configuration: 64-bit data, 16 registers, three read ports.
    @(posedge clk);
    #1;
    c_wr_en   = 1'b1;
    c_wr_addr = 4'd15;
    c_wr_data = 64'hFFFF_0000_1234_5678;
    c_rd_addr = {4'd15, 4'd15, 4'd15};
    #2;
    checkOutput("wide bypass p2", c_rd_data[128 +: 64], 64'hFFFF_0000_1234_5678);
    @(posedge clk);
    #1;
    c_wr_en    = 1'b0;
    c_rsv_en   = 1'b1;
    c_rsv_addr = 4'd15;
    #2;
    for (int p = 0; p < 3; p++) begin
      checkOutput($sformatf("wide data p%0d", p), c_rd_data[p*64 +: 64], 64'hFFFF_0000_1234_5678);
    end
    checkOutput("wide rsv hidden", {61'd0, c_rd_busy}, 64'd0);
    @(posedge clk);
    #1;
    c_rsv_en = 1'b0;
    #2;
    checkOutput("wide busy ports", {61'd0, c_rd_busy}, 64'h7);
    checkOutput("wide busy_vec", {48'd0, c_busy_vec}, 64'h8000);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-write, dual-read RV32I register file.
- Generalises register width, register count and number of read ports.
- Adds write-to-read bypass, so writes move from the falling edge to the rising edge.
- Adds asynchronous clear and a per-register busy scoreboard, so a pipelined core can detect pending writebacks.
- Sits between decode (read and reserve) and writeback (write and release).

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers; must be a power of 2 and at least 2.
- NUM_RD, 2, number of combinational read ports; 1 to 4.
- AW, $clog2(NREGS), address width; derived, not overridden.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  port i's register has a reservation outstanding.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- rsv_en  in  1  issue-stage reservation strobe.
- rsv_addr  in  AW  destination being reserved.
- busy_vec  out  NREGS  full scoreboard; bit 0 is always 0.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, no clock needed):
  - All registers clear to 0.
  - All busy bits clear to 0.
  - rd_data reflects 0 for every address.
  - rd_busy and busy_vec are 0.
- Reset mid-operation: any in-flight wr_en or rsv_en in the cycle rst_n falls is discarded. The first write accepted is on the first rising edge with rst_n high.
- Register 0 is hardwired to zero:
  - Writes to address 0 are ignored.
  - Reservations of address 0 are ignored.
  - Reads of address 0 return 0 and rd_busy = 0, regardless of bypass.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, registers[wr_addr] <= wr_data.
- Read: combinational, zero latency.
- Bypass:
  - With BYPASS=1, wr_en=1, wr_addr==rd_addr[i] and address !=0, rd_data[i] = wr_data in the same cycle.
  - Otherwise rd_data[i] = stored value.
  - With BYPASS=0, the new value is visible the cycle after the write edge.
- Scoreboard, per register r != 0, at the rising edge:
  - set = rsv_en && rsv_addr==r.
  - clr = wr_en && wr_addr==r.
  - set && clr: busy[r] <= 1. A reservation in the same cycle as a release means a newer producer, so busy stays set.
  - set only: busy[r] <= 1. A reservation of an already-busy register is legal and keeps it busy; no count is kept.
  - clr only: busy[r] <= 0.
  - Neither: hold.
- rd_busy[i]:
  - Equals busy[rd_addr[i]], except when BYPASS=1 and a same-cycle write to that address is present and not re-reserved in that cycle; then rd_busy[i] = 0, because the data is being forwarded.
  - rd_busy[i] does not see a same-cycle rsv_en; the reservation becomes visible next cycle.
- A write to a non-busy register is legal: it updates data and busy stays 0.
- Multiple read ports addressing the same register all return identical data and busy status.
- Out-of-range parameters (NUM_RD > 4, NREGS not a power of 2) stop elaboration via a static assertion.

Decomposition:
- Package reg_file_pkg holds:
  - Default constants XLEN_DEF=32, NREGS_DEF=32.
  - Function addr_w(n) returning $clog2(n).
  - Typedef reg_addr_t (logic [4:0]) and reg_data_t (logic [31:0]) for the default RV32I configuration.
- Sub-module reg_scoreboard:
  - Parameters NREGS, NUM_RD.
  - Holds the busy flops with asynchronous clear, the set/clear priority logic, busy_vec and per-port busy lookup.
- The top level holds the data array, write logic, read muxes with bypass, and the bypass qualification of rd_busy.

Test Plan:
1. Reset and x0:
   - Stimulus: assert rst_n=0 mid-cycle, then release; then write 0xDEADBEEF to address 0, read address 0 and address 5.
   - Response: rd_data=0 and busy_vec=0 immediately on reset. After the write to address 0, reading it gives rd_data=0 and rd_busy=0, and address 5 reads 0.
2. Basic write/read, default parameters:
   - Stimulus: write 0x12345678 to address 7, then read address 7 on port 0 and port 1 on the next cycle.
   - Response: both ports return 0x12345678.
3. Bypass:
   - Stimulus: BYPASS=1, wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5, with rd_addr port 1 = 9 in the same cycle.
   - Response: rd_data port 1 = 0xA5A5A5A5 before the edge.
   - Repeat with BYPASS=0: old value before the edge, new value after it.
4. Scoreboard lifecycle:
   - Stimulus: reserve address 3; read it next cycle; write 0x55 to address 3; read it after the write edge.
   - Response: rd_busy=1 and busy_vec[3]=1 after the reservation; rd_busy=0 during the write cycle (bypass); busy_vec[3]=0 after the write edge.
5. Simultaneous reserve and release:
   - Stimulus: address 4 busy; rsv_en and wr_en both target 4 in one cycle with wr_data=0x77.
   - Response: next cycle reads 0x77 with busy_vec[4]=1.
   - Also drive rsv_en for address 0. Response: busy_vec[0]=0.
6. Parameter sweep:
   - Stimulus: XLEN=64, NREGS=16, NUM_RD=3; write 0xFFFF_0000_1234_5678 to address 15, read it on all three ports.
   - Response: identical data on all three ports, with AW=4.
